// File: rtl/psum_accumulator.sv
// psum_accumulator: captures unskewed psum rows from the systolic array and
// accumulates them across K-passes into a DEPTH x NUM_COLS flop buffer, then
// drains the finished tile one row per valid/ready beat.
// Optional feature macro: ACC_SATURATE_EN (per-lane signed clamp on overflow);
// when undefined, accumulation wraps modulo 2^ACC_WIDTH.

// One accumulator column: DEPTH wide signed entries for a single lane.
module psum_acc_lane #(
    parameter int PSUM_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int DEPTH      = 16,
    parameter int PW         = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  first,
    input  logic [PW-1:0]         wr_ptr,
    input  logic [PW-1:0]         rd_ptr,
    input  logic [PSUM_WIDTH-1:0] psum,
    output logic [ACC_WIDTH-1:0]  rd_data
);
    logic signed [ACC_WIDTH-1:0]  mem [DEPTH];
    logic signed [PSUM_WIDTH-1:0] psum_s;
    logic signed [ACC_WIDTH-1:0]  ext, cur, sum, nxt;

    assign psum_s  = psum;
    assign ext     = ACC_WIDTH'(psum_s);
    assign cur     = mem[wr_ptr];
    assign rd_data = mem[rd_ptr];

`ifdef ACC_SATURATE_EN
    logic [ACC_WIDTH:0] wide;
    assign wide = {cur[ACC_WIDTH-1], cur} + {ext[ACC_WIDTH-1], ext};

    // Clamp to the signed range when the two top bits of the wide sum disagree.
    always_comb begin
        sum = wide[ACC_WIDTH-1:0];
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])
            sum = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`else
    assign sum = cur + ext;
`endif

    // First pass overwrites, so no clear cycle is needed between tiles.
    assign nxt = first ? ext : sum;

    // Buffer entries are not reset; every row is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= nxt;
    end
endmodule

module psum_accumulator #(
    parameter int PSUM_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_COLS   = 16,
    parameter int DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [7:0]                     cfg_num_passes,
    input  logic                           psum_valid,
    input  logic [NUM_COLS*PSUM_WIDTH-1:0] psum_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_COLS*ACC_WIDTH-1:0]  out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_ROW = PW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    pass_cnt, passes;
    logic          wr_en;

    assign wr_en     = (state == S_ACCUM) && psum_valid;
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DRAIN);
    assign out_last  = out_valid && (rd_ptr == LAST_ROW);

    // Control FSM: tile start, row/pass bookkeeping, drain handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pass_cnt <= '0;
            passes   <= 8'd1;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ACCUM;
                        passes   <= (cfg_num_passes == 8'd0) ? 8'd1 : cfg_num_passes;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        pass_cnt <= '0;
                        overrun  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (psum_valid) begin
                        if (wr_ptr == LAST_ROW) begin
                            wr_ptr   <= '0;
                            pass_cnt <= pass_cnt + 8'd1;
                            if (pass_cnt == passes - 8'd1) state <= S_DRAIN;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Rows arriving now have nowhere to go; flag until next start.
                    if (psum_valid) overrun <= 1'b1;
                    if (out_ready) begin
                        if (rd_ptr == LAST_ROW) begin
                            state  <= S_IDLE;
                            done   <= 1'b1;
                            rd_ptr <= '0;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_lane
        psum_acc_lane #(
            .PSUM_WIDTH (PSUM_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .DEPTH      (DEPTH),
            .PW         (PW)
        ) u_lane (
            .clk     (clk),
            .wr_en   (wr_en),
            .first   (pass_cnt == 8'd0),
            .wr_ptr  (wr_ptr),
            .rd_ptr  (rd_ptr),
            .psum    (psum_in[i*PSUM_WIDTH +: PSUM_WIDTH]),
            .rd_data (out_data[i*ACC_WIDTH +: ACC_WIDTH])
        );
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: randomized scoreboard bench. Two instances share all
// inputs: a 32-bit accumulator and a 16-bit one (exercises wrap or, with
// ACC_SATURATE_EN, clamping). Expected rows are queued by the driver and
// popped by an independent monitor on each accepted beat.
module tb_psum_accumulator;
    localparam int NC  = 16;
    localparam int DP  = 16;
    localparam int PWD = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        cfg_num_passes = 8'd0;
    logic              psum_valid = 1'b0;
    logic [NC*PWD-1:0] psum_in = '0;
    logic              out_ready = 1'b0;

    logic              ov32, ol32, busy32, done32, ovr32;
    logic [NC*32-1:0]  od32;
    logic              ov16, ol16, busy16, done16, ovr16;
    logic [NC*16-1:0]  od16;

    typedef struct { logic [NC*32-1:0] d; logic last; } beat32_t;
    typedef struct { logic [NC*16-1:0] d; logic last; } beat16_t;
    beat32_t q32[$];
    beat16_t q16[$];

    longint m32 [DP][NC];
    longint m16 [DP][NC];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  exp_done = 1'b0;
    int  bp_idx = 0;

    always #5 clk = ~clk;

    psum_accumulator #(.PSUM_WIDTH(16), .ACC_WIDTH(32), .NUM_COLS(NC), .DEPTH(DP)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .cfg_num_passes(cfg_num_passes),
        .psum_valid(psum_valid), .psum_in(psum_in), .out_valid(ov32), .out_ready(out_ready),
        .out_data(od32), .out_last(ol32), .busy(busy32), .done(done32), .overrun(ovr32));

    psum_accumulator #(.PSUM_WIDTH(16), .ACC_WIDTH(16), .NUM_COLS(NC), .DEPTH(DP)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .cfg_num_passes(cfg_num_passes),
        .psum_valid(psum_valid), .psum_in(psum_in), .out_valid(ov16), .out_ready(out_ready),
        .out_data(od16), .out_last(ol16), .busy(busy16), .done(done16), .overrun(ovr16));

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference accumulate: first pass loads, later passes add; result is
    // then wrapped or clamped to a w-bit signed value.
    function automatic longint acc_step(input longint a, input longint p, input int w, input bit first);
        longint r, lo, hi, m;
        r  = first ? p : a + p;
        m  = longint'(1) << w;
        hi = (m / 2) - 1;
        lo = -(m / 2);
`ifdef ACC_SATURATE_EN
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`else
        r = r & (m - 1);
        if (r > hi) r = r - m;
`endif
        return r;
    endfunction

    function automatic longint gen(input int dmode, input int ps, input int r, input int i);
        logic [15:0] u;
        case (dmode)
            0:       return longint'(r * 16 + i);
            1:       return -2;
            2:       return (ps == 0) ? 32767 : 1;
            default: begin u = 16'($urandom); return longint'($signed(u)); end
        endcase
    endfunction

    function automatic bit bp_val(input int bpmode);
        case (bpmode)
            0:       return 1'b1;
            1:       return (bp_idx % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic push_tile();
        beat32_t b32;
        beat16_t b16;
        logic [63:0] v;
        for (int r = 0; r < DP; r++) begin
            for (int i = 0; i < NC; i++) begin
                v = 64'(m32[r][i]); b32.d[i*32 +: 32] = v[31:0];
                v = 64'(m16[r][i]); b16.d[i*16 +: 16] = v[15:0];
            end
            b32.last = (r == DP - 1);
            b16.last = (r == DP - 1);
            q32.push_back(b32);
            q16.push_back(b16);
        end
    endtask

    task automatic run_tile(input int cfg, input int dmode, input int bpmode, input bit noise);
        int     p, k;
        bit     ovr;
        longint v;
        logic [NC*PWD-1:0] row;
        logic [63:0] vb;
        p   = (cfg == 0) ? 1 : cfg;
        ovr = 1'b0;
        start = 1'b1; cfg_num_passes = 8'(cfg);
        step();
        start = 1'b0;
        chk("busy_after_start", {busy32, busy16}, 2'b11);
        chk("overrun_cleared", {ovr32, ovr16}, 2'b00);
        for (int ps = 0; ps < p; ps++) begin
            for (int r = 0; r < DP; r++) begin
                // Idle gaps, with an ignored restart attempt when noisy.
                while ($urandom_range(0, 3) == 0) begin
                    psum_valid = 1'b0;
                    start = noise; cfg_num_passes = 8'd7;
                    step();
                    start = 1'b0;
                end
                for (int i = 0; i < NC; i++) begin
                    v  = gen(dmode, ps, r, i);
                    vb = 64'(v);
                    row[i*PWD +: PWD] = vb[15:0];
                    m32[r][i] = acc_step(m32[r][i], v, 32, ps == 0);
                    m16[r][i] = acc_step(m16[r][i], v, 16, ps == 0);
                end
                psum_valid = 1'b1; psum_in = row;
                if (ps == p - 1 && r == DP - 1) push_tile();
                step();
            end
        end
        psum_valid = 1'b0;
        chk("first_valid_latency", {ov32, ov16}, 2'b11);
        k = 0;
        bp_idx = 0;
        while (busy32 && k < 400) begin
            out_ready = bp_val(bpmode);
            bp_idx++;
            if (noise) begin
                psum_valid = ($urandom_range(0, 3) == 0);
                start      = ($urandom_range(0, 3) == 0);
                psum_in    = {NC*PWD/32{$urandom}};
                if (psum_valid) ovr = 1'b1;
            end
            step();
            k++;
        end
        psum_valid = 1'b0; start = 1'b0;
        if (k >= 400) chk("drain_timeout", 1'b1, 1'b0);
        chk("overrun_flag", {ovr32, ovr16}, {ovr, ovr});
        chk("idle_after_drain", {busy32, busy16, ov32, ov16}, 4'b0000);
    endtask

    // Monitor: compares every presented row against the queue head, pops on
    // accept, and expects done exactly one cycle after the final beat.
    always @(negedge clk) begin
        if (rst) begin
            exp_done = 1'b0;
        end else begin
            chk("done_pulse", {done32, done16}, {exp_done, exp_done});
            exp_done = 1'b0;
            if (ov32) begin
                if (q32.size() == 0) chk("unexpected_beat32", 1'b1, 1'b0);
                else begin
                    chk("data32", od32, q32[0].d);
                    chk("last32", ol32, q32[0].last);
                    if (out_ready) begin
                        exp_done = q32[0].last;
                        void'(q32.pop_front());
                    end
                end
            end
            if (ov16) begin
                if (q16.size() == 0) chk("unexpected_beat16", 1'b1, 1'b0);
                else begin
                    chk("data16", od16, q16[0].d);
                    chk("last16", ol16, q16[0].last);
                    if (out_ready) void'(q16.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        chk("reset_outputs", {busy32, ov32, ol32, done32, ovr32, busy16, ov16, done16, ovr16}, 9'd0);
        rst = 1'b0;
        step();

        run_tile(1, 0, 0, 1'b0);   // ramp, single pass
        run_tile(3, 1, 1, 1'b0);   // three passes of -2, 1-0-0 backpressure
        run_tile(0, 3, 2, 1'b1);   // zero passes, restart attempts, overrun
        run_tile(2, 2, 0, 1'b0);   // 0x7FFF + 1 overflow on 16-bit lanes
        chk("overrun_cleared_later", {ovr32, ovr16}, 2'b00);

        // Abort a tile mid-accumulation.
        start = 1'b1; cfg_num_passes = 8'd2;
        step();
        start = 1'b0;
        for (int n = 0; n < DP + 7; n++) begin
            psum_valid = 1'b1; psum_in = {NC*PWD/32{$urandom}};
            step();
        end
        rst = 1'b1;
        step();
        chk("rst_mid_accum", {busy32, ov32, busy16, ov16}, 4'b0000);
        rst = 1'b0; psum_valid = 1'b0;
        step();

        run_tile(2, 3, 2, 1'b0);
        run_tile(4, 3, 1, 1'b1);
        for (int t = 0; t < 3; t++) run_tile($urandom_range(1, 3), 3, 2, 1'(t));

        repeat (4) step();
        chk("queue32_empty", 32'(q32.size()), 32'd0);
        chk("queue16_empty", 32'(q16.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
